// File: rtl/keypad_pkg.sv
// Shared key codes, FSM states and defaults for the keypad time-entry front end.
package keypad_pkg;

  localparam logic [3:0] KEY_POT   = 4'hA;
  localparam logic [3:0] KEY_START = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] R_DEFAULT = 4'd9;

  typedef enum logic [1:0] {
    ENTRY,
    POWER,
    LOCKED
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the raw scanner key and emits one registered event per press.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       evt,
  output logic [3:0] evt_code
);

  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [3:0]    prev_key;
  logic          prev_valid;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          armed;
  logic          stable;

  // A key only counts as stable when it was also valid on the previous cycle,
  // so the first held cycle always starts the count at zero.
  always_comb begin
    stable  = key_valid && prev_valid && (key == prev_key);
    cnt_nxt = '0;
    if (stable)
      cnt_nxt = (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_key   <= '0;
      prev_valid <= 1'b0;
      cnt        <= '0;
      armed      <= 1'b1;
      evt        <= 1'b0;
      evt_code   <= '0;
    end else begin
      prev_key   <= key;
      prev_valid <= key_valid;
      cnt        <= cnt_nxt;
      evt        <= 1'b0;
      if (!key_valid) begin
        armed <= 1'b1;
      end else if (armed && cnt_nxt == CNT_LAST) begin
        evt      <= 1'b1;
        evt_code <= key;
        armed    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad front end: assembles BCD cook time, power level and a door-gated start strobe.
module keypad_time_entry
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        key_valid,
  input  logic        porta,
  output logic [11:0] t,
  output logic [3:0]  r,
  output logic        conf,
  output logic        err,
  output logic        locked
);

  logic        evt;
  logic [3:0]  evt_code;
  state_t      state, state_nxt;
  logic [11:0] t_nxt;
  logic [3:0]  r_nxt;
  logic        conf_nxt, err_nxt, locked_nxt;
  logic        start_ok;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .key_valid(key_valid),
    .evt      (evt),
    .evt_code (evt_code)
  );

  // A start needs a closed door, a non-zero time and a legal seconds-tens digit.
  assign start_ok = !porta && (t != 12'h000) && (t[7:4] <= 4'd5);

  always_comb begin
    state_nxt  = state;
    t_nxt      = t;
    r_nxt      = r;
    conf_nxt   = 1'b0;
    err_nxt    = 1'b0;
    locked_nxt = locked;
    if (evt) begin
      unique case (state)
        ENTRY: begin
          if (is_digit(evt_code)) begin
            t_nxt = {t[7:0], evt_code};
          end else if (evt_code == KEY_POT) begin
            state_nxt = POWER;
          end else if (evt_code == KEY_CLEAR) begin
            t_nxt = 12'h000;
            r_nxt = R_DEFAULT;
          end else if (evt_code == KEY_START) begin
            if (start_ok) begin
              conf_nxt   = 1'b1;
              locked_nxt = 1'b1;
              state_nxt  = LOCKED;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        POWER: begin
          if (is_digit(evt_code)) begin
            r_nxt     = evt_code;
            state_nxt = ENTRY;
          end else if (evt_code == KEY_CLEAR) begin
            r_nxt     = R_DEFAULT;
            state_nxt = ENTRY;
          end
        end
        LOCKED: begin
          if (evt_code == KEY_CLEAR) begin
            t_nxt      = 12'h000;
            r_nxt      = R_DEFAULT;
            locked_nxt = 1'b0;
            state_nxt  = ENTRY;
          end
        end
        default: state_nxt = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ENTRY;
      t      <= 12'h000;
      r      <= R_DEFAULT;
      conf   <= 1'b0;
      err    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      t      <= t_nxt;
      r      <= r_nxt;
      conf   <= conf_nxt;
      err    <= err_nxt;
      locked <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Randomized bench for keypad_time_entry against a digit-level reference model.
module tb_keypad_time_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic        key_valid;
  logic        porta;
  logic [11:0] t;
  logic [3:0]  r;
  logic        conf, err, locked;

  int total = 0;
  int bad   = 0;

  // reference model: three digits, power, mode (0 entry, 1 power, 2 locked)
  int m_min, m_tens, m_units, m_r, m_mode;
  int exp_conf = 0, exp_err = 0;
  int conf_cyc = 0, err_cyc = 0, both_cyc = 0;

  keypad_time_entry #(.DEB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .key_valid(key_valid),
    .porta    (porta),
    .t        (t),
    .r        (r),
    .conf     (conf),
    .err      (err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (conf) conf_cyc++;
      if (err) err_cyc++;
      if (conf && err) both_cyc++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [11:0] m_t();
    return {4'(m_min), 4'(m_tens), 4'(m_units)};
  endfunction

  task automatic model_reset();
    m_min = 0; m_tens = 0; m_units = 0; m_r = 9; m_mode = 0;
  endtask

  task automatic model_key(input int code);
    if (m_mode == 0) begin
      if (code <= 9) begin
        m_min = m_tens; m_tens = m_units; m_units = code;
      end else if (code == 10) begin
        m_mode = 1;
      end else if (code == 12) begin
        m_min = 0; m_tens = 0; m_units = 0; m_r = 9;
      end else if (code == 11) begin
        if (!porta && (m_min + m_tens + m_units) != 0 && m_tens <= 5) begin
          exp_conf++; m_mode = 2;
        end else begin
          exp_err++;
        end
      end
    end else if (m_mode == 1) begin
      if (code <= 9) begin
        m_r = code; m_mode = 0;
      end else if (code == 12) begin
        m_r = 9; m_mode = 0;
      end
    end else begin
      if (code == 12) begin
        m_min = 0; m_tens = 0; m_units = 0; m_r = 9; m_mode = 0;
      end
    end
  endtask

  task automatic press(input int code, input int hold, input int rel);
    @(posedge clk); #1;
    key = 4'(code); key_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    key_valid = 1'b0;
    model_key(code);
    repeat (rel) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key = 4'h0; key_valid = 1'b0; porta = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (t !== 12'h000) begin bad++; $display("FAIL reset_t got=%h exp=000", t); end
    total++; if (r !== 4'd9) begin bad++; $display("FAIL reset_r got=%h exp=9", r); end
    total++; if (conf !== 1'b0) begin bad++; $display("FAIL reset_conf got=%b exp=0", conf); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_digit_shift();
    press(1, 6, 2);
    press(3, 6, 2);
    @(posedge clk); #1;
    key = 4'h0; key_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (t !== m_t()) begin bad++; $display("FAIL shift_early got=%h exp=%h", t, m_t()); end
    @(posedge clk); #1;
    model_key(0);
    total++; if (t !== m_t() || t !== 12'h130) begin bad++; $display("FAIL shift_t got=%h exp=%h", t, m_t()); end
    total++; if (conf !== 1'b0) begin bad++; $display("FAIL shift_conf got=%b exp=0", conf); end
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_bounce();
    @(posedge clk); #1;
    key = 4'h5;
    for (int i = 0; i < 10; i++) begin
      key_valid = (i % 2 == 0);
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (t !== m_t()) begin bad++; $display("FAIL bounce_nochange got=%h exp=%h", t, m_t()); end
    press(5, 20, 2);
    total++; if (t !== m_t()) begin bad++; $display("FAIL bounce_single got=%h exp=%h", t, m_t()); end
  endtask

  task automatic test_power_start();
    porta = 1'b0;
    press(12, 6, 2);
    press(0, 6, 2);
    press(4, 6, 2);
    press(5, 6, 2);
    press(10, 6, 2);
    press(7, 6, 2);
    total++; if (r !== 4'(m_r)) begin bad++; $display("FAIL power_r got=%h exp=%0d", r, m_r); end
    press(11, 6, 2);
    total++; if (conf_cyc !== exp_conf) begin bad++; $display("FAIL start_conf got=%0d exp=%0d", conf_cyc, exp_conf); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL start_locked got=%b exp=1", locked); end
    press(1, 6, 2);
    press(2, 6, 2);
    total++; if (t !== m_t() || t !== 12'h045) begin bad++; $display("FAIL locked_hold got=%h exp=%h", t, m_t()); end
    total++; if (err_cyc !== exp_err) begin bad++; $display("FAIL start_err got=%0d exp=%0d", err_cyc, exp_err); end
  endtask

  task automatic test_clear_locked();
    press(12, 6, 2);
    total++; if (t !== m_t()) begin bad++; $display("FAIL clr_t got=%h exp=%h", t, m_t()); end
    total++; if (r !== 4'(m_r)) begin bad++; $display("FAIL clr_r got=%h exp=%0d", r, m_r); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL clr_locked got=%b exp=0", locked); end
    press(8, 6, 2);
    total++; if (t !== m_t() || t !== 12'h008) begin bad++; $display("FAIL clr_digit got=%h exp=%h", t, m_t()); end
  endtask

  task automatic test_rejects();
    porta = 1'b1;
    press(11, 6, 2);
    total++; if (err_cyc !== exp_err) begin bad++; $display("FAIL rej_door_err got=%0d exp=%0d", err_cyc, exp_err); end
    total++; if (conf_cyc !== exp_conf || locked !== 1'b0) begin bad++; $display("FAIL rej_door_conf got=%0d/%b exp=%0d/0", conf_cyc, locked, exp_conf); end
    porta = 1'b0;
    press(12, 6, 2);
    press(11, 6, 2);
    total++; if (err_cyc !== exp_err) begin bad++; $display("FAIL rej_zero_err got=%0d exp=%0d", err_cyc, exp_err); end
    total++; if (conf_cyc !== exp_conf || locked !== 1'b0) begin bad++; $display("FAIL rej_zero_conf got=%0d/%b exp=%0d/0", conf_cyc, locked, exp_conf); end
    press(1, 6, 2);
    press(7, 6, 2);
    press(0, 6, 2);
    press(11, 6, 2);
    total++; if (err_cyc !== exp_err) begin bad++; $display("FAIL rej_tens_err got=%0d exp=%0d", err_cyc, exp_err); end
    total++; if (conf_cyc !== exp_conf || locked !== 1'b0) begin bad++; $display("FAIL rej_tens_conf got=%0d/%b exp=%0d/0", conf_cyc, locked, exp_conf); end
    total++; if (t !== m_t() || t !== 12'h170) begin bad++; $display("FAIL rej_tens_t got=%h exp=%h", t, m_t()); end
  endtask

  task automatic test_reset_midpress();
    @(posedge clk); #1;
    key = 4'h2; key_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    total++; if (t !== 12'h000 || r !== 4'd9) begin bad++; $display("FAIL midrst_tr got=%h/%h exp=000/9", t, r); end
    total++; if (conf !== 1'b0 || err !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL midrst_ctl got=%b%b%b exp=000", conf, err, locked); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (t !== m_t()) begin bad++; $display("FAIL midrst_early got=%h exp=%h", t, m_t()); end
    @(posedge clk); #1;
    model_key(2);
    total++; if (t !== m_t()) begin bad++; $display("FAIL midrst_accept got=%h exp=%h", t, m_t()); end
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int code;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) code = 10 + $urandom_range(0, 5);
      else code = $urandom_range(0, 9);
      porta = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        key = 4'($urandom_range(0, 15));
        for (int i = 0; i < 6; i++) begin
          key_valid = (i % 2 == 0);
          @(posedge clk); #1;
        end
        key_valid = 1'b0;
      end
      press(code, $urandom_range(5, 8), $urandom_range(1, 3));
      total++; if (t !== m_t() || r !== 4'(m_r)) begin bad++; $display("FAIL rnd_tr n=%0d code=%0d got=%h/%h exp=%h/%0d", n, code, t, r, m_t(), m_r); end
      total++; if (locked !== (m_mode == 2)) begin bad++; $display("FAIL rnd_locked n=%0d got=%b exp=%0d", n, locked, m_mode == 2); end
      total++; if (conf_cyc !== exp_conf || err_cyc !== exp_err) begin bad++; $display("FAIL rnd_strobe n=%0d got=%0d/%0d exp=%0d/%0d", n, conf_cyc, err_cyc, exp_conf, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_digit_shift();
    test_bounce();
    test_power_start();
    test_clear_locked();
    test_rejects();
    test_reset_midpress();
    test_random();
    total++; if (both_cyc !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", both_cyc); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
